param_report_tx: RTL and testbench
==================================

PARAM_REPORT_TX -- requirements
Module: param_report_tx

Interface
REQ-001 Parameter HEADER, default 8'hA5, first byte of every report packet.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 report_req  input  1  single-cycle request to send one parameter report.
REQ-005 waveform_type  input  2  current waveform selection.
REQ-006 frequency  input  16  current frequency word.
REQ-007 amplitude  input  10  current amplitude.
REQ-008 dc_offset  input  10  current DC offset.
REQ-009 tx_busy  input  1  UART transmitter busy; high while a byte is shifting out.
REQ-010 tx_data  output  8  byte presented to UART transmitter.
REQ-011 tx_start  output  1  one-cycle strobe; tx_data valid in the same cycle.
REQ-012 report_busy  output  1  high from request acceptance until the packet completes.
REQ-013 report_done  output  1  one-cycle pulse after the last byte finishes.

Function
REQ-014 Packet is 9 bytes, in order: HEADER, {6'b0,waveform_type}, frequency[15:8], frequency[7:0], {6'b0,amplitude[9:8]}, amplitude[7:0], {6'b0,dc_offset[9:8]}, dc_offset[7:0], checksum.
REQ-015 Checksum is the bitwise XOR of bytes 0..7, HEADER included.
REQ-016 All four parameter inputs are snapshotted into internal registers in the cycle report_req is accepted; input changes afterwards do not affect the packet in flight.
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
REQ-018 IDLE: report_req high -> snapshot, byte index = 0, report_busy = 1, go to ISSUE.
REQ-019 ISSUE: if tx_busy low, drive tx_data = byte[index], tx_start = 1 for exactly one cycle, go to WAIT_ACK; if tx_busy high, hold in ISSUE with tx_start = 0.
REQ-020 WAIT_ACK: stay until tx_busy observed high, then go to WAIT_DONE.
REQ-021 WAIT_ACK timeout: if tx_busy not seen high within 16 cycles after tx_start, treat the byte as sent and proceed as if WAIT_DONE completed.
REQ-022 WAIT_DONE: on tx_busy low, if index = 8 go to FINISH, else index increments by 1 and go to ISSUE.
REQ-023 FINISH: report_done = 1 for one cycle, report_busy = 0, return to IDLE (or ISSUE per REQ-025).
REQ-024 Minimum latency: report_req at cycle N with tx_busy low -> tx_start with HEADER at cycle N+2.
REQ-025 report_req while report_busy is high sets a single pending flag (further requests do not stack); at FINISH a set pending flag causes a fresh snapshot and a new packet, and the flag clears.
REQ-026 report_req in the same cycle as FINISH is treated as pending (REQ-025).
REQ-027 tx_data holds its last value when tx_start is low; no tx_start is ever issued while tx_busy is high.
REQ-028 Byte index is 4 bits, never exceeds 8, and resets to 0 at each new packet.

Reset
REQ-029 On rst: state = IDLE, tx_start = 0, tx_data = 8'h00, report_busy = 0, report_done = 0, index = 0, pending = 0, snapshot registers = 0, timeout counter = 0.
REQ-030 rst asserted mid-packet aborts it immediately, with no further tx_start; after release, the block waits for a new report_req.

Verification
REQ-031 Inputs wf=2'b01, freq=16'h1234, amp=10'h3FF, off=10'h200, one report_req, UART model busy 10 cycles per byte -> bytes A5 01 12 34 03 FF 02 00 7C, then one report_done pulse.
REQ-032 Reset-default values wf=0, freq=16'h0001, amp=10'h3FF, off=10'h200 -> A5 00 00 01 03 FF 02 00 5A.
REQ-033 Change freq to 16'hBEEF during byte 2 of a packet -> packet still carries 12 34 and checksum 7C.
REQ-034 Three report_req pulses during one packet -> exactly two packets total, back to back, each ending in report_done.
REQ-035 tx_busy held high 5 cycles before the first ISSUE -> tx_start is delayed until tx_busy falls; tx_busy stuck low (no ack) -> each byte advances after the 16-cycle timeout, and all 9 tx_start strobes appear.
REQ-036 rst pulse after the 4th tx_start -> all outputs go to reset values asynchronously, no further strobes; a new report_req then yields a complete 9-byte packet.

Source files
------------

// File: rtl/param_report_tx.sv
// Serialises a snapshot of the waveform parameters into a 9-byte report packet
// (header, payload, XOR checksum) handed one byte at a time to a UART transmitter.
module param_report_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        report_req,
  input  logic [1:0]  waveform_type,
  input  logic [15:0] frequency,
  input  logic [9:0]  amplitude,
  input  logic [9:0]  dc_offset,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        report_busy,
  output logic        report_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  localparam logic [3:0] LAST_IDX    = 4'd8;
  localparam logic [3:0] ACK_TIMEOUT = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        pend_q, pend_d;
  logic [1:0]  wf_q, wf_d;
  logic [15:0] freq_q, freq_d;
  logic [9:0]  amp_q, amp_d;
  logic [9:0]  off_q, off_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;

  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic        snap;
  logic        byte_done;

  assign checksum = HEADER ^ {6'b0, wf_q} ^ freq_q[15:8] ^ freq_q[7:0]
                  ^ {6'b0, amp_q[9:8]} ^ amp_q[7:0]
                  ^ {6'b0, off_q[9:8]} ^ off_q[7:0];

  always_comb begin
    // NOTE: assign a default before the case so no path leaves cur_byte unassigned (that would infer a latch).
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = {6'b0, wf_q};
      4'd2:    cur_byte = freq_q[15:8];
      4'd3:    cur_byte = freq_q[7:0];
      4'd4:    cur_byte = {6'b0, amp_q[9:8]};
      4'd5:    cur_byte = amp_q[7:0];
      4'd6:    cur_byte = {6'b0, off_q[9:8]};
      4'd7:    cur_byte = off_q[7:0];
      4'd8:    cur_byte = checksum;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    snap       = 1'b0;
    byte_done  = 1'b0;

    // Requests arriving while a packet is in flight collapse into one pending flag.
    if (report_req && state_q != S_IDLE) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (report_req) begin
          snap    = 1'b1;
          idx_d   = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          tmo_d      = 4'd0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy)                  state_d   = S_WAIT_DONE;
        else if (tmo_q == ACK_TIMEOUT) byte_done = 1'b1;
        else                          tmo_d     = tmo_q + 4'd1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) byte_done = 1'b1;
      end
      S_FINISH: begin
        if (pend_q || report_req) begin
          snap    = 1'b1;
          pend_d  = 1'b0;
          idx_d   = 4'd0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte finishes either on the UART handshake or on the missing-ack timeout.
    if (byte_done) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_FINISH;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_ISSUE;
      end
    end
  end

  assign wf_d   = snap ? waveform_type : wf_q;
  assign freq_d = snap ? frequency     : freq_q;
  assign amp_d  = snap ? amplitude     : amp_q;
  assign off_d  = snap ? dc_offset     : off_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      tmo_q      <= 4'd0;
      pend_q     <= 1'b0;
      wf_q       <= 2'd0;
      freq_q     <= 16'd0;
      amp_q      <= 10'd0;
      off_q      <= 10'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      wf_q       <= wf_d;
      freq_q     <= freq_d;
      amp_q      <= amp_d;
      off_q      <= off_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign report_busy = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
  assign report_done = (state_q == S_FINISH);

endmodule

// File: tb/tb_param_report_tx.sv
// Self-checking bench for param_report_tx: a UART responder on the falling edge plus
// a packet reference model built directly from the packet layout.
module tb_param_report_tx;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        report_req = 1'b0;
  logic [1:0]  waveform_type = '0;
  logic [15:0] frequency = '0;
  logic [9:0]  amplitude = '0;
  logic [9:0]  dc_offset = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        report_busy;
  logic        report_done;

  always #5 clk = ~clk;

  param_report_tx #(.HEADER(HDR)) dut (
    .clk           (clk),
    .rst           (rst),
    .report_req    (report_req),
    .waveform_type (waveform_type),
    .frequency     (frequency),
    .amplitude     (amplitude),
    .dc_offset     (dc_offset),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .report_busy   (report_busy),
    .report_done   (report_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         fall_cyc[$];
  int         done_cnt = 0;
  int         viol_cnt = 0;
  int         cyc = 0;
  bit         uart_ack = 1'b1;
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         hold_cnt = 0;

  typedef logic [7:0] pkt_t [9];

  function automatic pkt_t ref_packet(logic [1:0] wf, logic [15:0] fr, logic [9:0] am, logic [9:0] of);
    pkt_t p;
    p[0] = HDR;
    p[1] = {6'b0, wf};
    p[2] = fr[15:8];
    p[3] = fr[7:0];
    p[4] = {6'b0, am[9:8]};
    p[5] = am[7:0];
    p[6] = {6'b0, of[9:8]};
    p[7] = of[7:0];
    p[8] = 8'h00;
    for (int i = 0; i < 8; i++) p[8] = p[8] ^ p[i];
    return p;
  endfunction

  task automatic push_expected(input logic [1:0] wf, input logic [15:0] fr,
                               input logic [9:0] am, input logic [9:0] of);
    pkt_t p;
    p = ref_packet(wf, fr, am, of);
    for (int i = 0; i < 9; i++) exp_q.push_back(p[i]);
  endtask

  // UART responder: captures each strobed byte and holds busy for busy_len cycles.
  initial begin
    forever begin
      bit prev;
      @(negedge clk);
      cyc++;
      prev = tx_busy;
      if (rst) begin
        busy_cnt = 0;
        hold_cnt = 0;
        tx_busy  = 1'b0;
      end else if (tx_start) begin
        if (tx_busy) viol_cnt++;
        rx_q.push_back(tx_data);
        start_cyc.push_back(cyc);
        if (uart_ack) begin
          tx_busy  = 1'b1;
          busy_cnt = busy_len;
        end
      end else if (hold_cnt > 0) begin
        tx_busy = 1'b1;
        hold_cnt--;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end else begin
        tx_busy = 1'b0;
      end
      if (prev && !tx_busy) fall_cyc.push_back(cyc);
      if (report_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic clear_log();
    rx_q.delete();
    exp_q.delete();
    start_cyc.delete();
    fall_cyc.delete();
    done_cnt = 0;
    viol_cnt = 0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (report_busy === 1'b0 && report_done === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_params(input logic [1:0] wf, input logic [15:0] fr,
                            input logic [9:0] am, input logic [9:0] of);
    waveform_type = wf;
    frequency     = fr;
    amplitude     = am;
    dc_offset     = of;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data);
    else n_pass++;
    n_checks++;
    if (report_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", report_busy);
    else n_pass++;
    n_checks++;
    if (report_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", report_done);
    else n_pass++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_latency_vector();
    bit ok;
    clear_log();
    busy_len = 10;
    set_params(2'b01, 16'h1234, 10'h3FF, 10'h200);
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h03, 8'hFF, 8'h02, 8'h00, 8'h7C};
    pulse_req();
    n_checks++;
    if (tx_start !== 1'b0 || report_busy !== 1'b1)
      $display("FAIL latency_n1: got start=%b busy=%b expected start=0 busy=1", tx_start, report_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== HDR)
      $display("FAIL latency_n2: got start=%b data=%h expected start=1 data=%h", tx_start, tx_data, HDR);
    else n_pass++;
    wait_idle(400, ok);
    n_checks++;
    if (!ok) $display("FAIL vector_timeout: got busy after 400 cycles expected idle");
    else n_pass++;
    n_checks++;
    if (rx_q.size() != 9) $display("FAIL vector_count: got %0d bytes expected 9", rx_q.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL vector_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt != 1 || viol_cnt != 0)
      $display("FAIL vector_done: got done=%0d viol=%0d expected done=1 viol=0", done_cnt, viol_cnt);
    else n_pass++;
  endtask

  task automatic test_defaults();
    bit ok;
    clear_log();
    set_params(2'b00, 16'h0001, 10'h3FF, 10'h200);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h03, 8'hFF, 8'h02, 8'h00, 8'h5A};
    pulse_req();
    wait_idle(400, ok);
    n_checks++;
    if (!ok || rx_q.size() != 9) $display("FAIL defaults_count: got %0d bytes ok=%b expected 9", rx_q.size(), ok);
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL defaults_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    clear_log();
    set_params(2'b01, 16'h1234, 10'h3FF, 10'h200);
    push_expected(2'b01, 16'h1234, 10'h3FF, 10'h200);
    pulse_req();
    wait_bytes(2, 200, ok);
    frequency = 16'hBEEF;
    wait_idle(400, ok);
    n_checks++;
    if (!ok || rx_q.size() != 9) $display("FAIL snapshot_count: got %0d bytes ok=%b expected 9", rx_q.size(), ok);
    else n_pass++;
    n_checks++;
    if (rx_q.size() == 9 && (rx_q[2] !== 8'h12 || rx_q[3] !== 8'h34 || rx_q[8] !== 8'h7C))
      $display("FAIL snapshot_bytes: got %h %h cks %h expected 12 34 cks 7c", rx_q[2], rx_q[3], rx_q[8]);
    else if (rx_q.size() == 9) n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    busy_len = 4;
    set_params(2'b10, 16'hA55A, 10'h155, 10'h2AA);
    push_expected(2'b10, 16'hA55A, 10'h155, 10'h2AA);
    push_expected(2'b11, 16'h0F0F, 10'h001, 10'h3FE);
    pulse_req();
    repeat (3) tick();
    pulse_req();
    repeat (5) tick();
    pulse_req();
    tick();
    pulse_req();
    set_params(2'b11, 16'h0F0F, 10'h001, 10'h3FE);
    wait_idle(800, ok);
    n_checks++;
    if (!ok || rx_q.size() != 18 || done_cnt != 2)
      $display("FAIL b2b_count: got %0d bytes %0d dones expected 18 bytes 2 dones", rx_q.size(), done_cnt);
    else n_pass++;
    for (int i = 0; i < 18 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
    busy_len = 10;
  endtask

  task automatic test_busy_hold();
    bit ok;
    clear_log();
    set_params(2'b01, 16'hC0DE, 10'h0AB, 10'h1CD);
    push_expected(2'b01, 16'hC0DE, 10'h0AB, 10'h1CD);
    hold_cnt = 7;
    tick();
    pulse_req();
    wait_idle(400, ok);
    n_checks++;
    if (!ok || rx_q.size() != 9 || viol_cnt != 0)
      $display("FAIL hold_count: got %0d bytes viol=%0d expected 9 bytes viol=0", rx_q.size(), viol_cnt);
    else n_pass++;
    n_checks++;
    if (start_cyc.size() == 0 || fall_cyc.size() == 0 || start_cyc[0] != fall_cyc[0] + 1)
      $display("FAIL hold_first_start: got start cycle %0d expected one after busy fall", start_cyc.size() ? start_cyc[0] : -1);
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL hold_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit gap_ok;
    clear_log();
    uart_ack = 1'b0;
    set_params(2'b10, 16'h8001, 10'h300, 10'h0FF);
    push_expected(2'b10, 16'h8001, 10'h300, 10'h0FF);
    pulse_req();
    wait_idle(400, ok);
    n_checks++;
    if (!ok || rx_q.size() != 9 || done_cnt != 1)
      $display("FAIL timeout_count: got %0d strobes %0d dones expected 9 strobes 1 done", rx_q.size(), done_cnt);
    else n_pass++;
    gap_ok = 1'b1;
    for (int i = 1; i < start_cyc.size(); i++)
      if (start_cyc[i] - start_cyc[i-1] < 16 || start_cyc[i] - start_cyc[i-1] > 18) gap_ok = 1'b0;
    n_checks++;
    if (!gap_ok || start_cyc.size() < 2)
      $display("FAIL timeout_gap: got strobe spacing outside 16..18 cycles expected ack timeout spacing");
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL timeout_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
    uart_ack = 1'b1;
  endtask

  task automatic test_reset_abort();
    bit ok;
    clear_log();
    busy_len = 6;
    set_params(2'b11, 16'h4321, 10'h123, 10'h321);
    pulse_req();
    wait_bytes(4, 200, ok);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || report_busy !== 1'b0 || report_done !== 1'b0)
      $display("FAIL abort_outputs: got start=%b data=%h busy=%b done=%b expected all zero",
               tx_start, tx_data, report_busy, report_done);
    else n_pass++;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (rx_q.size() != 4 || report_busy !== 1'b0)
      $display("FAIL abort_quiet: got %0d strobes busy=%b expected 4 strobes busy=0", rx_q.size(), report_busy);
    else n_pass++;
    clear_log();
    push_expected(2'b11, 16'h4321, 10'h123, 10'h321);
    pulse_req();
    wait_idle(400, ok);
    n_checks++;
    if (!ok || rx_q.size() != 9 || done_cnt != 1)
      $display("FAIL abort_restart: got %0d bytes %0d dones expected 9 bytes 1 done", rx_q.size(), done_cnt);
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL abort_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      else n_pass++;
    end
    busy_len = 10;
  endtask

  task automatic test_random();
    bit ok;
    for (int t = 0; t < 6; t++) begin
      logic [1:0]  wf;
      logic [15:0] fr;
      logic [9:0]  am;
      logic [9:0]  of;
      wf = 2'($urandom);
      fr = 16'($urandom);
      am = 10'($urandom);
      of = 10'($urandom);
      clear_log();
      busy_len = int'($urandom_range(1, 12));
      set_params(wf, fr, am, of);
      push_expected(wf, fr, am, of);
      pulse_req();
      set_params(2'($urandom), 16'($urandom), 10'($urandom), 10'($urandom));
      wait_idle(400, ok);
      n_checks++;
      if (!ok || rx_q.size() != 9 || done_cnt != 1 || viol_cnt != 0)
        $display("FAIL rand%0d_count: got %0d bytes %0d dones viol=%0d expected 9/1/0", t, rx_q.size(), done_cnt, viol_cnt);
      else n_pass++;
      for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_q[i]) $display("FAIL rand%0d_byte%0d: got %h expected %h", t, i, rx_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    busy_len = 10;
  endtask

  initial begin
    test_reset();
    test_latency_vector();
    test_defaults();
    test_snapshot();
    test_back_to_back();
    test_busy_hold();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
